// File: rtl/bp_peak_detector.sv
// Peak detector for the digitised band-pass filter output.
// Tracks max/min over a window and hands out max, min, pk-pk and clip.
module bp_peak_detector #(
    parameter int DATA_W = 12,
    parameter int WIN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] pk_max,
    output logic [DATA_W-1:0] pk_min,
    output logic [DATA_W:0]   pk2pk,
    output logic              clip
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_HOLD
    } state_e;

    localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   len_q, len_d;
    logic [WIN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic               hit_q, hit_d;
    logic [DATA_W-1:0]  pk_max_q, pk_max_d;
    logic [DATA_W-1:0]  pk_min_q, pk_min_d;
    logic [DATA_W:0]    pk2pk_q, pk2pk_d;
    logic               clip_q, clip_d;

    logic [DATA_W-1:0]  run_max;
    logic [DATA_W-1:0]  run_min;
    logic               is_fs;

    // State and datapath registers; reset aborts any measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            max_q    <= '0;
            min_q    <= '0;
            hit_q    <= 1'b0;
            pk_max_q <= '0;
            pk_min_q <= '0;
            pk2pk_q  <= '0;
            clip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            max_q    <= max_d;
            min_q    <= min_d;
            hit_q    <= hit_d;
            pk_max_q <= pk_max_d;
            pk_min_q <= pk_min_d;
            pk2pk_q  <= pk2pk_d;
            clip_q   <= clip_d;
        end
    end

    // Next-state logic: window control, running extremes, result capture.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        max_d    = max_q;
        min_d    = min_q;
        hit_d    = hit_q;
        pk_max_d = pk_max_q;
        pk_min_d = pk_min_q;
        pk2pk_d  = pk2pk_q;
        clip_d   = clip_q;

        run_max = sample;
        run_min = sample;
        if (!first_q) begin
            if ($signed(max_q) > $signed(sample)) run_max = max_q;
            if ($signed(min_q) < $signed(sample)) run_min = min_q;
        end
        is_fs = (sample == POS_FS) || (sample == NEG_FS);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = (win_len == '0) ? WIN_W'(1) : win_len;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (sample_valid) begin
                    max_d   = run_max;
                    min_d   = run_min;
                    hit_d   = hit_q | is_fs;
                    cnt_d   = cnt_q + WIN_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == len_q - WIN_W'(1)) begin
                        state_d  = S_HOLD;
                        pk_max_d = run_max;
                        pk_min_d = run_min;
                        pk2pk_d  = {run_max[DATA_W-1], run_max}
                                 - {run_min[DATA_W-1], run_min};
                        clip_d   = hit_q | is_fs;
                    end
                end
            end
            S_HOLD: begin
                if (result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_HOLD);
    assign pk_max       = pk_max_q;
    assign pk_min       = pk_min_q;
    assign pk2pk        = pk2pk_q;
    assign clip         = clip_q;

endmodule

// File: tb/tb_bp_peak_detector.sv
// Scoreboard bench for bp_peak_detector with a queue-based window model.
// Stimulus pushes expected results; a monitor pops them on handshake.
module tb_bp_peak_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] win_len;
    logic        sample_valid;
    logic [11:0] sample;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [11:0] pk_max;
    logic [11:0] pk_min;
    logic [12:0] pk2pk;
    logic        clip;

    typedef struct {
        int mx;
        int mn;
        int p2p;
        bit clp;
    } exp_t;

    exp_t exp_q[$];
    int   dir_q[$];
    int   checks = 0;
    int   errors = 0;

    bp_peak_detector #(.DATA_W(12), .WIN_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .win_len(win_len),
        .sample_valid(sample_valid),
        .sample(sample),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .pk_max(pk_max),
        .pk_min(pk_min),
        .pk2pk(pk2pk),
        .clip(clip)
    );

    always #5 clk = ~clk;

    function automatic int sx(logic [11:0] b);
        return int'($signed(b));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: window extremes straight from the list of accepted samples.
    function automatic exp_t model(int w[$]);
        exp_t e;
        e.mx  = w[0];
        e.mn  = w[0];
        e.clp = 1'b0;
        foreach (w[i]) begin
            if (w[i] > e.mx) e.mx = w[i];
            if (w[i] < e.mn) e.mn = w[i];
            if (w[i] == 2047 || w[i] == -2048) e.clp = 1'b1;
        end
        e.p2p = e.mx - e.mn;
        return e;
    endfunction

    function automatic int rnd_val();
        int r;
        r = int'($urandom_range(15));
        if (r == 0) return 2047;
        if (r == 1) return -2048;
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // Monitor: every result_valid cycle must match the queue head.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("sb_max", sx(pk_max), exp_q[0].mx);
                chk("sb_min", sx(pk_min), exp_q[0].mn);
                chk("sb_p2p", int'(pk2pk), exp_q[0].p2p);
                chk("sb_clip", int'(clip), int'(exp_q[0].clp));
                if (result_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_win(input int len, input int gaps,
                           input int hold, input bit noise,
                           input bit b2b);
        int   eff;
        int   v;
        int   g;
        int   win[$];
        exp_t e;
        eff = (len == 0) ? 1 : len;
        start   = 1'b1;
        win_len = 16'(len);
        step();
        chk("busy_after_start", int'(busy), 1);
        start = 1'b0;
        for (int i = 0; i < eff; i++) begin
            g = (gaps > 0) ? int'($urandom_range(gaps)) : 0;
            for (int k = 0; k < g; k++) begin
                sample_valid = 1'b0;
                sample = 12'($urandom_range(4095));
                step();
            end
            v = (dir_q.size() > 0) ? dir_q.pop_front() : rnd_val();
            win.push_back(v);
            sample_valid = 1'b1;
            sample = 12'(v);
            if (i == eff - 1) begin
                e = model(win);
                exp_q.push_back(e);
            end
            step();
        end
        sample_valid = 1'b0;
        chk("valid_latency", int'(result_valid), 1);
        for (int c = 0; c < hold; c++) begin
            if (noise) begin
                sample_valid = 1'($urandom_range(1));
                sample  = 12'($urandom_range(4095));
                start   = 1'($urandom_range(1));
                win_len = 16'($urandom_range(9));
            end
            step();
            chk("hold_valid", int'(result_valid), 1);
        end
        sample_valid = 1'b0;
        start = b2b;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        start = 1'b0;
        chk("valid_drop", int'(result_valid), 0);
        chk("busy_drop", int'(busy), 0);
        chk("idle_keep_max", sx(pk_max), e.mx);
        chk("idle_keep_p2p", int'(pk2pk), e.p2p);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        win_len = '0;
        sample_valid = 1'b0;
        sample = '0;
        result_ready = 1'b0;
        #23;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_p2p", int'(pk2pk), 0);
        chk("rst_clip", int'(clip), 0);
        rst = 1'b0;
        step();

        dir_q = '{100, -300, 250, 0};
        run_win(4, 0, 0, 1'b0, 1'b0);
        chk("basic_max", sx(pk_max), 250);
        chk("basic_min", sx(pk_min), -300);
        chk("basic_p2p", int'(pk2pk), 550);
        chk("basic_clip", int'(clip), 0);

        dir_q = '{2047, -2048};
        run_win(2, 0, 0, 1'b0, 1'b0);
        chk("fs_p2p", int'(pk2pk), 4095);
        chk("fs_clip", int'(clip), 1);

        dir_q = '{-7};
        run_win(0, 0, 0, 1'b0, 1'b0);
        chk("len0_max", sx(pk_max), -7);
        chk("len0_min", sx(pk_min), -7);
        chk("len0_p2p", int'(pk2pk), 0);

        run_win(3, 3, 0, 1'b0, 1'b0);
        run_win(5, 1, 10, 1'b1, 1'b0);
        run_win(4, 0, 0, 1'b0, 1'b1);
        run_win(3, 0, 2, 1'b0, 1'b0);

        start = 1'b1;
        win_len = 16'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample = 12'($urandom_range(4095));
            step();
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(result_valid), 0);
        chk("arst_max", sx(pk_max), 0);
        chk("arst_min", sx(pk_min), 0);
        chk("arst_p2p", int'(pk2pk), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        dir_q = '{5, -5};
        run_win(2, 0, 0, 1'b0, 1'b0);
        chk("arst_new_p2p", int'(pk2pk), 10);

        for (int n = 0; n < 30; n++) begin
            run_win(int'($urandom_range(20)), int'($urandom_range(2)),
                    int'($urandom_range(4)), 1'($urandom_range(1)),
                    1'($urandom_range(1)));
        end

        step();
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
